// File: rtl/dly_vec_sequencer.sv
// Stimulus sequencer for the (a & b) | c gate-delay circuit: accepts a vector, drives it,
// samples the circuit output after SETTLE cycles and keeps running vector/error counts.
module dly_vec_sequencer #(
    parameter int SETTLE = 2,
    parameter int HOLD_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vec_valid,
    output logic              vec_ready,
    input  logic [2:0]        vec_abc,
    input  logic [HOLD_W-1:0] vec_hold,
    output logic              a_o,
    output logic              b_o,
    output logic              c_o,
    input  logic              d_out,
    output logic              res_valid,
    output logic              res_out,
    output logic              res_err,
    output logic [CNT_W-1:0]  vec_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, APPLY, HOLD} state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

    state_t            state, state_nxt;
    logic [3:0]        settle_tmr;
    logic [HOLD_W-1:0] hold_tmr;
    logic [HOLD_W-1:0] hold_len;
    logic              expected;
    logic              accept;
    logic              sample;
    logic              mismatch;

    assign vec_ready = (state == IDLE) & ~reset;
    assign busy      = (state != IDLE);
    assign mismatch  = d_out ^ expected;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        sample    = 1'b0;
        case (state)
            IDLE: begin
                if (vec_valid && vec_ready) begin
                    accept    = 1'b1;
                    state_nxt = APPLY;
                end
            end
            APPLY: begin
                if (settle_tmr == '0) begin
                    sample    = 1'b1;
                    state_nxt = (hold_len != '0) ? HOLD : IDLE;
                end
            end
            HOLD: begin
                if (hold_tmr == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            settle_tmr <= '0;
            hold_tmr   <= '0;
            hold_len   <= '0;
            expected   <= 1'b0;
            a_o        <= 1'b0;
            b_o        <= 1'b0;
            c_o        <= 1'b0;
            res_valid  <= 1'b0;
            res_out    <= 1'b0;
            res_err    <= 1'b0;
            vec_cnt    <= '0;
            err_cnt    <= '0;
        end else begin
            state     <= state_nxt;
            res_valid <= sample;

            // Circuit inputs only change on accept, so they hold the last vector between samples.
            if (accept) begin
                {a_o, b_o, c_o} <= vec_abc;
                expected        <= (vec_abc[2] & vec_abc[1]) | vec_abc[0];
                hold_len        <= vec_hold;
                settle_tmr      <= SETTLE_LD;
            end

            if (state == APPLY && !sample) settle_tmr <= settle_tmr - 4'd1;

            if (sample) begin
                res_out  <= d_out;
                res_err  <= mismatch;
                vec_cnt  <= vec_cnt + CNT_W'(1);
                hold_tmr <= hold_len - HOLD_W'(1);
                if (mismatch && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
            end

            if (state == HOLD && hold_tmr != '0) hold_tmr <= hold_tmr - HOLD_W'(1);
        end
    end

endmodule

// File: tb/tb_dly_vec_sequencer.sv
// Self-checking bench for dly_vec_sequencer: directed test-plan vectors plus randomized
// traffic checked against a transaction-level model with behavioural fast/slow circuits.
module tb_dly_vec_sequencer;

    localparam int SETTLE = 2;
    localparam int HOLD_W = 4;
    localparam int CNT_W  = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              vec_valid = 1'b0;
    logic              vec_ready;
    logic [2:0]        vec_abc = '0;
    logic [HOLD_W-1:0] vec_hold = '0;
    logic              a_o, b_o, c_o;
    logic              d_out;
    logic              res_valid, res_out, res_err;
    logic [CNT_W-1:0]  vec_cnt, err_cnt;
    logic              busy;

    dly_vec_sequencer #(.SETTLE(SETTLE), .HOLD_W(HOLD_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .vec_valid(vec_valid), .vec_ready(vec_ready),
        .vec_abc(vec_abc), .vec_hold(vec_hold), .a_o(a_o), .b_o(b_o), .c_o(c_o),
        .d_out(d_out), .res_valid(res_valid), .res_out(res_out), .res_err(res_err),
        .vec_cnt(vec_cnt), .err_cnt(err_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    // Circuit models: fast meets a 20-unit settle window, slow (25) does not.
    logic d_fast = 1'b0, d_slow = 1'b0;
    int   mode = 0;  // 0 fast circuit, 1 output tied 0, 2 slow circuit
    always @(a_o or b_o or c_o) begin
        d_fast <= #9  (a_o & b_o) | c_o;
        d_slow <= #25 (a_o & b_o) | c_o;
    end
    assign d_out = (mode == 0) ? d_fast : (mode == 1) ? 1'b0 : d_slow;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model state
    int         ready_edge = 0;
    int         sample_edge = -1;
    logic [2:0] last_abc = '0;
    int         m_vec = 0, m_err = 0;
    logic       m_res = 1'b0, m_rerr = 1'b0;

    function automatic logic fn(input logic [2:0] v);
        return (v[2] & v[1]) | v[0];
    endfunction

    // Called at a negedge; returns at a negedge with vec_valid low.
    task automatic send(input logic [2:0] abc, input int hold, input int gap);
        bit   ok;
        int   acc;
        int   first_valid;
        logic dval;
        ok = 0;
        first_valid = cyc + 1 + gap;
        for (int i = 0; i < 80 && !ok; i++) begin
            vec_valid = (i >= gap);
            vec_abc   = (i >= gap) ? abc : 3'($urandom);
            vec_hold  = (i >= gap) ? HOLD_W'(hold) : HOLD_W'($urandom);
            #1;
            chk("ready", vec_ready, (cyc + 1 >= ready_edge));
            chk("abc_hold", {a_o, b_o, c_o}, last_abc);
            chk("res_strobe", res_valid, (cyc == sample_edge));
            chk("res_keep", {res_out, res_err}, {m_res, m_rerr});
            ok = vec_ready & vec_valid;
            @(posedge clk); #1;
            if (!ok) @(negedge clk);
        end
        if (!ok) begin
            chk("accept_timeout", 0, 1);
            vec_valid = 1'b0;
            @(negedge clk);
            return;
        end
        acc = cyc;
        chk("accept_edge", acc, (ready_edge > first_valid) ? ready_edge : first_valid);
        chk("abc_applied", {a_o, b_o, c_o}, abc);
        chk("busy", busy, 1);
        chk("ready_busy", vec_ready, 0);

        dval = (mode == 0) ? fn(abc) : (mode == 1) ? 1'b0 : fn(last_abc);
        m_res  = dval;
        m_rerr = dval ^ fn(abc);
        m_vec  = (m_vec + 1) % (CNT_MAX + 1);
        if (m_rerr && m_err < CNT_MAX) m_err++;
        last_abc    = abc;
        sample_edge = acc + SETTLE;
        ready_edge  = acc + SETTLE + hold + 1;

        // Inputs are scrambled mid-vector; the DUT must ignore them.
        for (int k = 1; k < SETTLE; k++) begin
            vec_abc = 3'($urandom); vec_hold = HOLD_W'($urandom); vec_valid = 1'($urandom);
            @(posedge clk); #1;
            chk("early_strobe", res_valid, 0);
        end
        vec_abc = 3'($urandom); vec_hold = HOLD_W'($urandom);
        @(posedge clk); #1;
        chk("sample_edge", cyc, sample_edge);
        chk("res_valid", res_valid, 1);
        chk("res_out", res_out, m_res);
        chk("res_err", res_err, m_rerr);
        chk("vec_cnt", vec_cnt, m_vec);
        chk("err_cnt", err_cnt, m_err);
        chk("abc_kept", {a_o, b_o, c_o}, abc);
        vec_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", vec_ready, 0);
        chk("rst_outs", {a_o, b_o, c_o, res_valid, res_out, res_err, busy}, 0);
        chk("rst_cnts", {vec_cnt, err_cnt}, 0);
        @(negedge clk);
        reset = 1'b0;
        ready_edge = cyc + 1;

        // Real circuit, back-to-back
        mode = 0;
        send(3'b000, 0, 0);
        send(3'b111, 0, 0);
        send(3'b100, 0, 0);

        // Output stuck at 0
        mode = 1;
        send(3'b111, 0, 0);
        send(3'b001, 0, 0);
        send(3'b110, 0, 0);
        send(3'b010, 0, 0);

        // Hold timing with valid held high
        mode = 0;
        send(3'b011, 3, 0);
        send(3'b101, 0, 0);

        // Circuit slower than the settle window, then one that meets it
        mode = 2;
        send(3'b000, 0, 1);
        send(3'b111, 0, 0);
        mode = 0;
        send(3'b000, 0, 0);
        send(3'b111, 0, 0);

        // Counter saturation and wrap
        mode = 1;
        for (int i = 0; i < 300; i++) send(3'b111, 0, 0);

        // Reset one cycle after an accept
        mode = 0;
        vec_valid = 1'b1; vec_abc = 3'b111; vec_hold = '0;
        #1;
        chk("pre_rst_ready", vec_ready, (cyc + 1 >= ready_edge));
        @(posedge clk); #1;
        chk("pre_rst_busy", busy, 1);
        vec_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_outs", {a_o, b_o, c_o, res_valid, res_out, res_err, busy}, 0);
        chk("mid_rst_cnts", {vec_cnt, err_cnt}, 0);
        chk("mid_rst_ready", vec_ready, 0);
        @(posedge clk); #1;
        chk("mid_rst_nostrobe", res_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", vec_ready, 1);
        ready_edge = cyc + 1; sample_edge = -1; last_abc = '0;
        m_vec = 0; m_err = 0; m_res = 1'b0; m_rerr = 1'b0;
        @(negedge clk);
        send(3'b001, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            mode = int'($urandom_range(0, 2));
            send(3'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=%0d exp=0", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dly_vec_sequencer.md
# dly_vec_sequencer

Clocked stimulus sequencer for the two-level and/or gate-delay circuit (out = (a & b) | c). It accepts test vectors over a valid/ready handshake and drives them onto the circuit's a/b/c inputs. After a programmable settle time it samples the circuit output, checks it against the expected function, and reports the result plus running counts. It sits between a vector source (bench or ROM) and the combinational delay circuit, so gate-delay experiments run cycle-accurately instead of with hand-placed `#` delays.

## Interface
- SETTLE, 2: cycles from applying a vector to sampling d_out; legal range 1..15; must exceed the circuit's worst-case path delay (9 time units) in clock periods.
- HOLD_W, 4: width of the per-vector hold field.
- CNT_W, 8: width of the vector and error counters.

- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- vec_valid  in  1  source has a vector.
- vec_ready  out  1  block can accept a vector.
- vec_abc  in  3  {a,b,c} to apply; bit 2 = a.
- vec_hold  in  HOLD_W  extra idle cycles after the sample, before the next accept.
- a_o, b_o, c_o  out  1 each  drive circuit inputs a, b, c.
- d_out  in  1  circuit output.
- res_valid  out  1  one-cycle result strobe.
- res_out  out  1  sampled d_out.
- res_err  out  1  res_out != expected.
- vec_cnt  out  CNT_W  vectors sampled; wraps.
- err_cnt  out  CNT_W  mismatches; saturates at all-ones.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, APPLY, HOLD.
- vec_ready = (state == IDLE) & ~reset. No other state asserts it.
- IDLE, when vec_valid & vec_ready at an edge:
  - latch vec_abc into a_o/b_o/c_o;
  - latch expected = (a & b) | c from vec_abc;
  - latch vec_hold;
  - load settle timer with SETTLE-1;
  - go to APPLY.
- APPLY:
  - timer decrements each edge.
  - At the edge where timer == 0, sample d_out into res_out and compute res_err = res_out ^ expected.
  - Same edge: vec_cnt += 1 (wrap); err_cnt += res_err unless already all-ones.
  - Next state: HOLD with hold timer = vec_hold-1 if vec_hold != 0, else IDLE.
- HOLD: hold timer decrements each edge; at timer == 0 go to IDLE.
- a_o/b_o/c_o keep the last applied vector through HOLD and IDLE. They never glitch to 0 between vectors.
- vec_abc/vec_hold are ignored except at the accept edge. Changing them mid-vector has no effect.
- res_out/res_err keep their values until the next sample; only res_valid is a strobe.
- reset (any state, including mid-APPLY/HOLD):
  - next state IDLE; abandoned vector produces no res_valid;
  - a_o=b_o=c_o=0, res_valid=res_out=res_err=0, vec_cnt=err_cnt=0, busy=0, timers=0;
  - vec_ready is 0 while reset is high and 1 the first cycle after.

## Timing
- Accept at edge E0: a_o/b_o/c_o valid from E0, busy=1 from E0.
- Sample at edge E0+SETTLE; res_valid=1 for exactly the cycle after E0+SETTLE. Counters are updated in that same cycle.
- vec_hold=0: vec_ready=1 in the same cycle as res_valid. Next accept is possible at E0+SETTLE+1, giving a minimum period of SETTLE+1 cycles.
- vec_hold=H>0: IDLE (vec_ready=1) after edge E0+SETTLE+H. Next accept is at E0+SETTLE+H+1.
- Ready cannot depend on valid. Valid may be held across non-ready cycles; the vector is not consumed until the ready&valid edge.

## Test plan
- Basic vectors, SETTLE=2, hold=0, real circuit attached: {000, 111, 100} -> res_out 0, 1, 0; res_err=0 each; vec_cnt=3, err_cnt=0; res_valid 2 cycles after each accept; accepts every 3 cycles.
- Fault injection, d_out tied 0: vectors 111, 001, 110 -> res_err=1 on all three; err_cnt=3. Vector 010 -> res_err=0, err_cnt stays 3.
- Hold timing: vector 011 with vec_hold=3, vec_valid held high -> vec_ready low for SETTLE+3 cycles after accept; second accept exactly SETTLE+4 edges after the first; a_o/b_o/c_o stay 011 until then.
- Settle check with a behavioral circuit model whose delay exceeds SETTLE periods, stepping 000->111: SETTLE=1 -> res_out=0, res_err=1. SETTLE=2 at a delay that meets it -> res_out=1, res_err=0.
- Saturation/wrap, CNT_W=2, d_out tied 0, 5 vectors of 111 -> err_cnt sequence 1, 2, 3, 3, 3; vec_cnt sequence 1, 2, 3, 0, 1.
- Reset mid-operation: assert reset one cycle after accepting 111 -> no res_valid; all outputs 0 the cycle after reset; vec_ready=0 during reset, 1 the following cycle; the next vector 001 gives res_out=1, vec_cnt=1.
